alpha_store: RTL and testbench

- Sequencer and storage for the forward (alpha) recursion of the max-product decoder.
- Sits directly downstream of alpha_element and closes its feedback loop:
  - drives previousAlpha into alpha_element;
  - issues one trellis step at a time (in_valid to alpha_element, step request to the branch-metric source);
  - captures AlphaMetric on out_valid and stores every step's input alpha vector.
- After the block completes, the extrinsic/LLR stage reads the stored vectors by step index.

---
 rtl/alpha_store_pkg.sv | 31 +++
 rtl/alpha_store_ram.sv | 29 ++
 rtl/alpha_store.sv | 129 ++++++++++++
 tb/tb_alpha_store.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alpha_store_pkg.sv
// Shared types and constants for the max-product alpha/beta recursion stages.
package alpha_store_pkg;

  localparam int BITS     = 16;
  localparam int STATES   = 4;
  localparam int MAX_LEN  = 1024;
  localparam int LEN_BITS = $clog2(MAX_LEN + 1);
  localparam int IDX_BITS = $clog2(MAX_LEN);

  localparam logic [BITS-1:0] INIT_ZERO = 16'h0000;
  localparam logic [BITS-1:0] INIT_NEG  = 16'hFC00;  // half-precision -inf

  // Element [s] holds the metric of trellis state s.
  typedef logic [STATES-1:0][BITS-1:0] metric_vec_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FIN
  } alpha_state_e;

  function automatic metric_vec_t init_vec();
    metric_vec_t v;
    for (int s = 0; s < STATES; s++) begin
      v[s] = (s == 0) ? INIT_ZERO : INIT_NEG;
    end
    return v;
  endfunction

endpackage

// File: rtl/alpha_store_ram.sv
// Simple dual-port RAM: one write port, one registered read port (old data on collision).
module alpha_store_ram
  import alpha_store_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                we_i,
  input  logic [IDX_BITS-1:0] waddr_i,
  input  metric_vec_t         wdata_i,
  input  logic                re_i,
  input  logic [IDX_BITS-1:0] raddr_i,
  output metric_vec_t         rdata_o
);

  metric_vec_t mem_q [MAX_LEN];
  metric_vec_t rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/alpha_store.sv
// Alpha recursion sequencer: feeds previousAlpha to alpha_element one step at a time
// and stores each step's input alpha vector for later readback.
module alpha_store
  import alpha_store_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic [LEN_BITS-1:0] block_len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                step_req_o,
  output logic [IDX_BITS-1:0] step_idx_o,
  output metric_vec_t         prev_alpha_o,
  input  logic                alpha_valid_i,
  input  metric_vec_t         alpha_in_i,
  output metric_vec_t         final_alpha_o,
  input  logic                rd_en_i,
  input  logic [IDX_BITS-1:0] rd_addr_i,
  output logic                rd_valid_o,
  output metric_vec_t         rd_alpha_o,
  output logic                protocol_err_o
);

  localparam logic [LEN_BITS-1:0] MAX_LEN_L = LEN_BITS'(MAX_LEN);

  alpha_state_e        state_q, state_d;
  logic [LEN_BITS-1:0] k_q, k_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  metric_vec_t         prev_q, prev_d;
  metric_vec_t         final_q, final_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                rd_valid_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    len_d   = len_q;
    prev_d  = prev_q;
    final_d = final_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d  = block_len_i;
          k_d    = '0;
          prev_d = init_vec();
          busy_d = 1'b1;
          err_d  = 1'b0;
          if (block_len_i == '0 || block_len_i > MAX_LEN_L) begin
            state_d = ST_FIN;
            err_d   = (block_len_i > MAX_LEN_L);
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (alpha_valid_i) begin
          prev_d = alpha_in_i;
          k_d    = k_q + LEN_BITS'(1);
          if (k_q + LEN_BITS'(1) == len_q) begin
            final_d = alpha_in_i;
            state_d = ST_FIN;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
    // alpha_element may only answer while a step is outstanding
    if (alpha_valid_i && state_q != ST_WAIT) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      len_q      <= '0;
      prev_q     <= init_vec();
      final_q    <= init_vec();
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      len_q      <= len_d;
      prev_q     <= prev_d;
      final_q    <= final_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_valid_q <= rd_en_i;
    end
  end

  alpha_store_ram u_ram (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_i    (state_q == ST_ISSUE),
    .waddr_i (k_q[IDX_BITS-1:0]),
    .wdata_i (prev_q),
    .re_i    (rd_en_i),
    .raddr_i (rd_addr_i),
    .rdata_o (rd_alpha_o)
  );

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign step_req_o     = (state_q == ST_ISSUE);
  assign step_idx_o     = k_q[IDX_BITS-1:0];
  assign prev_alpha_o   = prev_q;
  assign final_alpha_o  = final_q;
  assign rd_valid_o     = rd_valid_q;
  assign protocol_err_o = err_q;

endmodule

// File: tb/tb_alpha_store.sv
// Directed bench for alpha_store with a behavioural alpha_element responder.
module tb_alpha_store;
  import alpha_store_pkg::*;

  logic                clk, rst_n, start, rd_en;
  logic [LEN_BITS-1:0] block_len;
  logic [IDX_BITS-1:0] rd_addr;
  logic                busy_o, done_o, step_req_o, rd_valid_o, err_o;
  logic [IDX_BITS-1:0] step_idx_o;
  metric_vec_t         prev_alpha_o, final_alpha_o, rd_alpha_o, alpha_in;
  logic                av_model, av_inj;

  int n_chk = 0, n_bad = 0, n_done = 0;
  logic [IDX_BITS-1:0] idx_q [$];

  int          lat = 1;
  bit          mode_inc = 1'b0;
  metric_vec_t cvec;
  int          pend = 0;
  metric_vec_t pend_v;

  alpha_store dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .block_len_i(block_len),
    .busy_o(busy_o), .done_o(done_o), .step_req_o(step_req_o), .step_idx_o(step_idx_o),
    .prev_alpha_o(prev_alpha_o), .alpha_valid_i(av_model | av_inj), .alpha_in_i(alpha_in),
    .final_alpha_o(final_alpha_o), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_valid_o(rd_valid_o), .rd_alpha_o(rd_alpha_o), .protocol_err_o(err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic metric_vec_t add_vec(input metric_vec_t v, input int n);
    metric_vec_t r;
    for (int s = 0; s < STATES; s++) r[s] = v[s] + BITS'(n);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // alpha_element model: answers each step_req after lat cycles
  initial begin
    av_model = 1'b0;
    alpha_in = '0;
    forever begin
      @(negedge clk);
      av_model = 1'b0;
      if (!rst_n) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            av_model = 1'b1;
            alpha_in = pend_v;
          end
        end
        if (step_req_o) begin
          pend   = lat;
          pend_v = mode_inc ? add_vec(prev_alpha_o, 1) : cvec;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (step_req_o) idx_q.push_back(step_idx_o);
      if (done_o) n_done++;
    end
  end

  task automatic start_block(input logic [LEN_BITS-1:0] k);
    @(negedge clk);
    start = 1'b1;
    block_len = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int  n;
    bit  timed_out;
    n = 0;
    timed_out = 1'b0;
    while (!done_o && !timed_out) begin
      @(negedge clk);
      n++;
      if (n > budget) timed_out = 1'b1;
    end
    chk({tag, "_timeout"}, 64'(timed_out), 64'd0);
  endtask

  task automatic rd_chk(input string tag, input int a, input metric_vec_t exp);
    @(negedge clk);
    rd_en = 1'b1;
    rd_addr = IDX_BITS'(a);
    @(negedge clk);
    rd_en = 1'b0;
    chk({tag, "_rdv"}, 64'(rd_valid_o), 64'd1);
    chk(tag, rd_alpha_o, exp);
  endtask

  metric_vec_t init_v;
  int          nd0;

  initial begin
    init_v = init_vec();
    cvec = '0;
    for (int s = 0; s < STATES; s++) cvec[s] = BITS'(s + 1);
    rst_n = 1'b0; start = 1'b0; block_len = '0; rd_en = 1'b0; rd_addr = '0; av_inj = 1'b0;

    // reset values
    #12;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_req", 64'(step_req_o), 64'd0);
    chk("rst_idx", 64'(step_idx_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_rdv", 64'(rd_valid_o), 64'd0);
    chk("rst_prev", prev_alpha_o, 64'hFC00_FC00_FC00_0000);
    chk("rst_final", final_alpha_o, 64'hFC00_FC00_FC00_0000);
    chk("rst_rd", rd_alpha_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // test 1: K=1, constant answer after 3 cycles
    mode_inc = 1'b0; lat = 3; idx_q.delete(); nd0 = n_done;
    start_block(1);
    wait_done("t1", 50);
    chk("t1_busy_at_done", 64'(busy_o), 64'd0);
    chk("t1_final", final_alpha_o, 64'h0004_0003_0002_0001);
    repeat (3) @(negedge clk);
    chk("t1_ndone", 64'(n_done - nd0), 64'd1);
    chk("t1_nreq", 64'(idx_q.size()), 64'd1);
    chk("t1_idx0", 64'(idx_q.size() > 0 ? idx_q[0] : 10'h3FF), 64'd0);
    rd_chk("t1_mem0", 0, 64'hFC00_FC00_FC00_0000);
    @(negedge clk);
    chk("t1_rdv_drop", 64'(rd_valid_o), 64'd0);

    // test 2: K=8, increment model, latency 1
    mode_inc = 1'b1; lat = 1; idx_q.delete();
    start_block(8);
    wait_done("t2", 100);
    chk("t2_final", final_alpha_o, add_vec(init_v, 8));
    chk("t2_nreq", 64'(idx_q.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      chk("t2_idx", 64'(i < idx_q.size() ? idx_q[i] : 10'h3FF), 64'(i));
    for (int i = 0; i < 8; i++) rd_chk("t2_mem", i, add_vec(init_v, i));

    // test 3: zero and oversize lengths
    idx_q.delete();
    start_block(0);
    chk("t3_done_early", 64'(done_o), 64'd0);
    chk("t3_busy", 64'(busy_o), 64'd1);
    @(negedge clk);
    chk("t3_done_2cyc", 64'(done_o), 64'd1);
    chk("t3_busy_fall", 64'(busy_o), 64'd0);
    chk("t3_err0", 64'(err_o), 64'd0);
    start_block(LEN_BITS'(MAX_LEN + 1));
    wait_done("t3b", 10);
    chk("t3_err1", 64'(err_o), 64'd1);
    chk("t3_nreq", 64'(idx_q.size()), 64'd0);

    // test 4: start while busy is ignored
    lat = 5; idx_q.delete(); nd0 = n_done;
    start_block(4);
    chk("t4_err_clr", 64'(err_o), 64'd0);
    repeat (6) @(negedge clk);
    start_block(2);
    wait_done("t4", 100);
    chk("t4_nreq", 64'(idx_q.size()), 64'd4);
    chk("t4_final", final_alpha_o, add_vec(init_v, 4));
    repeat (3) @(negedge clk);
    chk("t4_ndone", 64'(n_done - nd0), 64'd1);
    @(negedge clk); av_inj = 1'b1;
    @(negedge clk); av_inj = 1'b0;
    chk("t4_inj_err", 64'(err_o), 64'd1);
    repeat (3) @(negedge clk);
    chk("t4_err_hold", 64'(err_o), 64'd1);
    mode_inc = 1'b0; lat = 1;
    start_block(1);
    chk("t4_err_start_clr", 64'(err_o), 64'd0);
    wait_done("t4b", 20);

    // test 5: reset during step 3 of K=10
    mode_inc = 1'b1; lat = 1; nd0 = n_done;
    start_block(10);
    begin
      int n;
      n = 0;
      while (!(step_req_o && step_idx_o == 3) && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("t5_reach_step3", 64'(step_idx_o), 64'd3);
    end
    rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(busy_o), 64'd0);
    chk("t5_req", 64'(step_req_o), 64'd0);
    chk("t5_idx", 64'(step_idx_o), 64'd0);
    chk("t5_prev", prev_alpha_o, init_v);
    chk("t5_final", final_alpha_o, init_v);
    chk("t5_rd", rd_alpha_o, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_no_done", 64'(n_done - nd0), 64'd0);
    idx_q.delete();
    start_block(2);
    wait_done("t5b", 50);
    chk("t5b_final", final_alpha_o, add_vec(init_v, 2));
    chk("t5b_nreq", 64'(idx_q.size()), 64'd2);

    // test 6: read collides with write of step 1; memory[1] currently init+1
    mode_inc = 1'b0; lat = 2;
    start_block(2);
    begin
      int n;
      n = 0;
      while (!(step_req_o && step_idx_o == 1) && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("t6_reach_step1", 64'(step_idx_o), 64'd1);
    end
    rd_en = 1'b1; rd_addr = 1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("t6_rdv", 64'(rd_valid_o), 64'd1);
    chk("t6_old_data", rd_alpha_o, add_vec(init_v, 1));
    @(negedge clk);
    chk("t6_rdv_drop", 64'(rd_valid_o), 64'd0);
    wait_done("t6", 50);
    rd_chk("t6_new_data", 1, cvec);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

endmodule
